linked_list_fifo_drain: RTL and testbench

Consumer-side engine for linked_list_fifo. It picks non-empty queues using weighted round-robin and drives the pop/pop_fifo port. It absorbs the one-cycle pop-to-q read latency and presents the data as a valid/ready stream tagged with the source queue index. It sits between the shared-storage multi-queue FIFO and a downstream packer or serializer.

---
 rtl/linked_list_fifo_drain_pkg.sv | 29 ++
 rtl/linked_list_fifo_drain_rr.sv | 28 ++
 rtl/linked_list_fifo_drain.sv | 167 ++++++++++++++++
 tb/tb_linked_list_fifo_drain.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linked_list_fifo_drain_pkg.sv
// Shared definitions for the linked-list FIFO drain engine and its helpers.
package linked_list_fifo_drain_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } drain_state_e;

   // Number of bits needed to represent x (never less than 1)
   function automatic int unsigned log2(input int unsigned x);
      int unsigned n;
      n = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((x >> i) != 0) n = i + 1;
      end
      return n;
   endfunction

   // Occupancy counter width for a FIFO of the given total depth
   function automatic int unsigned cnt_w_of(input int unsigned depth);
      return log2(depth - 1) + 1;
   endfunction

   // Queue index width for the given number of queues
   function automatic int unsigned fw_of(input int unsigned fifos);
      return log2(fifos - 1);
   endfunction

endpackage

// File: rtl/linked_list_fifo_drain_rr.sv
// Combinational round-robin finder: first eligible entry at or after ptr.
module linked_list_fifo_drain_rr #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic          hit,
   output logic [IW-1:0] index
);

   // Walk N offsets from ptr, wrapping at N-1 so unused codes are never visited
   always_comb begin
      int unsigned k;
      hit   = 1'b0;
      index = '0;
      k     = 0;
      for (int unsigned off = 0; off < N; off++) begin
         k = 32'(ptr) + off;
         if (k >= N) k = k - N;
         if (!hit && eligible[IW'(k)]) begin
            hit   = 1'b1;
            index = IW'(k);
         end
      end
   end

endmodule

// File: rtl/linked_list_fifo_drain.sv
// Weighted round-robin consumer for linked_list_fifo: pops queues, absorbs the
// pop-to-data latency and presents a valid/ready stream tagged with the queue.
module linked_list_fifo_drain
   import linked_list_fifo_drain_pkg::*;
#(
   parameter  int unsigned WIDTH   = 8,
   parameter  int unsigned DEPTH   = 32,
   parameter  int unsigned FIFOS   = 8,
   parameter  int unsigned QUANTUM = 4,
   localparam int unsigned CNT_W   = cnt_w_of(DEPTH),
   localparam int unsigned FW      = fw_of(FIFOS)
) (
   input  logic                   rst,
   input  logic                   clk,
   input  logic [FIFOS-1:0]       drain_en,
   input  logic [FIFOS*CNT_W-1:0] ll_count,
   output logic                   ll_pop,
   output logic [FW-1:0]          ll_pop_fifo,
   input  logic [WIDTH-1:0]       ll_q,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [FW-1:0]          out_fifo,
   output logic                   busy
);

   localparam int unsigned BC_W = log2(QUANTUM);

   typedef struct packed {
      logic [FW-1:0]    fifo;
      logic [WIDTH-1:0] data;
   } entry_t;

   drain_state_e     state_q, state_d;
   logic [FW-1:0]    ptr_q, search_ptr;
   logic [FW-1:0]    grant_q, grant_d;
   logic [BC_W-1:0]  burst_q, burst_d;
   logic             inflight_q;
   logic [FW-1:0]    inflight_fifo_q;

   entry_t           buf_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       occ_q;
   logic             wr_en, rd_en;

   logic [CNT_W-1:0] cnt [FIFOS];
   logic [CNT_W-1:0] eff [FIFOS];
   logic [FIFOS-1:0] dec, eligible, underflow;

   logic             credit, burst_go;
   logic             rr_hit;
   logic [FW-1:0]    rr_index;
   logic             pop_c;
   logic [FW-1:0]    pop_fifo_c;

   // Eligibility: enabled and non-empty once last cycle's pop is taken off the lagging count
   always_comb begin
      for (int unsigned k = 0; k < FIFOS; k++) begin
         cnt[k]       = ll_count[k*CNT_W +: CNT_W];
         dec[k]       = inflight_q && (inflight_fifo_q == FW'(k));
         eff[k]       = cnt[k] - CNT_W'(dec[k]);
         eligible[k]  = drain_en[k] && (eff[k] != '0);
         underflow[k] = dec[k] && (cnt[k] == '0);
      end
   end

   // A pop needs a free buffer slot counting the word still in flight
   assign credit = (occ_q + {1'b0, inflight_q}) < 2'd2;

   // Burst continuation, and the pointer the idle search starts from this cycle
   always_comb begin
      burst_go   = (state_q == BURST) && eligible[grant_q] && (burst_q < BC_W'(QUANTUM));
      search_ptr = ptr_q;
      if ((state_q == BURST) && !burst_go)
         search_ptr = (grant_q == FW'(FIFOS - 1)) ? '0 : grant_q + FW'(1);
   end

   linked_list_fifo_drain_rr #(
      .N  (FIFOS),
      .IW (FW)
   ) u_rr (
      .eligible (eligible),
      .ptr      (search_ptr),
      .hit      (rr_hit),
      .index    (rr_index)
   );

   // Next state and pop decision; a finished burst falls straight into the idle search
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      burst_d    = burst_q;
      pop_c      = 1'b0;
      pop_fifo_c = '0;
      if (burst_go) begin
         if (credit) begin
            pop_c      = 1'b1;
            pop_fifo_c = grant_q;
            burst_d    = burst_q + BC_W'(1);
         end
      end else begin
         state_d = IDLE;
         if (credit && rr_hit) begin
            pop_c      = 1'b1;
            pop_fifo_c = rr_index;
            grant_d    = rr_index;
            burst_d    = BC_W'(1);
            state_d    = BURST;
         end
      end
   end

   // Arbiter state and in-flight pop tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ptr_q           <= '0;
         grant_q         <= '0;
         burst_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_fifo_q <= '0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= search_ptr;
         grant_q         <= grant_d;
         burst_q         <= burst_d;
         inflight_q      <= pop_c;
         inflight_fifo_q <= pop_fifo_c;
      end
   end

   assign wr_en = inflight_q;
   assign rd_en = out_valid & out_ready;

   // Two-entry output buffer capturing the FIFO read data one cycle after each pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         if (wr_en) begin
            buf_q[wr_ptr_q] <= '{fifo: inflight_fifo_q, data: ll_q};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (rd_en) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, wr_en} - {1'b0, rd_en};
      end
   end

   assign ll_pop      = pop_c & ~rst;
   assign ll_pop_fifo = rst ? '0 : pop_fifo_c;
   assign out_valid   = (occ_q != 2'd0);
   assign out_data    = buf_q[rd_ptr_q].data;
   assign out_fifo    = buf_q[rd_ptr_q].fifo;
   assign busy        = inflight_q | out_valid;

   // The lagging count always still includes a word popped last cycle
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) underflow == '0);

   // Credit keeps a landing word from ever meeting a full buffer
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                   !(wr_en && !rd_en && (occ_q == 2'd2)));

endmodule

// File: tb/tb_linked_list_fifo_drain.sv
// Bench for linked_list_fifo_drain: directed scenarios plus random traffic,
// checked every cycle against a queue-level model of the FIFO and the drain.
module tb_linked_list_fifo_drain;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 32;
   localparam int FIFOS   = 8;
   localparam int QUANTUM = 4;
   localparam int CNT_W   = 6;
   localparam int FW      = 3;

   logic                   rst, clk;
   logic [FIFOS-1:0]       drain_en;
   logic [FIFOS*CNT_W-1:0] ll_count;
   logic                   ll_pop;
   logic [FW-1:0]          ll_pop_fifo;
   logic [WIDTH-1:0]       ll_q;
   logic                   out_valid, out_ready;
   logic [WIDTH-1:0]       out_data;
   logic [FW-1:0]          out_fifo;
   logic                   busy;

   linked_list_fifo_drain #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS), .QUANTUM(QUANTUM)
   ) dut (
      .rst(rst), .clk(clk), .drain_en(drain_en), .ll_count(ll_count),
      .ll_pop(ll_pop), .ll_pop_fifo(ll_pop_fifo), .ll_q(ll_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_fifo(out_fifo), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: stored words per queue, and which queue was popped at the last edge
   logic [WIDTH-1:0] fq [FIFOS][$];
   bit               lag [FIFOS];

   // Drain model: output buffer contents, word in flight, arbitration bookkeeping
   int  bq_fifo[$];
   int  bq_data[$];
   bit  m_infl;
   int  m_infl_fifo, m_infl_data;
   int  m_ptr, m_cur, m_used;
   int  n_ptr, n_cur, n_used;

   int  plog[$];
   int  dlog_fifo[$];
   int  dlog_data[$];
   int  checks = 0;
   int  errors = 0;
   bit  rand_mode = 1'b0;
   int  exp2[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int total();
      int t = 0;
      for (int k = 0; k < FIFOS; k++) t += fq[k].size();
      return t;
   endfunction

   // The FIFO reports occupancy one pop late
   task automatic refresh_counts();
      for (int k = 0; k < FIFOS; k++)
         ll_count[k*CNT_W +: CNT_W] = CNT_W'(fq[k].size() + int'(lag[k]));
   endtask

   // A queue may be drained when enabled and it really holds a word
   function automatic bit elig(input int k);
      return drain_en[k] && (fq[k].size() > 0);
   endfunction

   task automatic model_clear();
      bq_fifo.delete();
      bq_data.delete();
      m_infl = 1'b0; m_infl_fifo = 0; m_infl_data = 0;
      m_ptr = 0; m_cur = -1; m_used = 0;
   endtask

   // Which queue is popped this cycle, following the weighted round-robin rules
   task automatic model_decide(output int ep);
      bit credit;
      credit = (bq_fifo.size() + int'(m_infl)) < 2;
      n_ptr = m_ptr; n_cur = m_cur; n_used = m_used; ep = -1;
      if (n_cur >= 0) begin
         if (elig(n_cur) && n_used < QUANTUM) begin
            if (credit) begin
               ep = n_cur;
               n_used++;
            end
         end else begin
            n_ptr = (n_cur + 1) % FIFOS;
            n_cur = -1;
         end
      end
      if (n_cur < 0 && credit) begin
         for (int o = 0; o < FIFOS; o++) begin
            int k;
            k = (n_ptr + o) % FIFOS;
            if (ep < 0 && elig(k)) begin
               ep = k; n_cur = k; n_used = 1;
            end
         end
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid",   32'(out_valid),   0);
      chk("rst_out_data",    32'(out_data),    0);
      chk("rst_out_fifo",    32'(out_fifo),    0);
      chk("rst_ll_pop",      32'(ll_pop),      0);
      chk("rst_ll_pop_fifo", 32'(ll_pop_fifo), 0);
      chk("rst_busy",        32'(busy),        0);
   endtask

   // One clock: drive, compare against the model, then advance the models
   task automatic step();
      int ep;
      int q;
      @(negedge clk);
      if (rand_mode) begin
         drain_en  = ($urandom_range(0, 5) == 0) ? FIFOS'($urandom) : '1;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && total() < DEPTH) begin
            q = $urandom_range(0, FIFOS - 1);
            fq[q].push_back(WIDTH'($urandom));
         end
      end
      refresh_counts();
      #1;
      model_decide(ep);
      chk("ll_pop", 32'(ll_pop), 32'(ep >= 0));
      if (ep >= 0) chk("ll_pop_fifo", 32'(ll_pop_fifo), 32'(ep));
      chk("out_valid", 32'(out_valid), 32'(bq_fifo.size() != 0));
      if (bq_fifo.size() != 0) begin
         chk("out_fifo", 32'(out_fifo), 32'(bq_fifo[0]));
         chk("out_data", 32'(out_data), 32'(bq_data[0]));
      end
      chk("busy", 32'(busy), 32'(m_infl || bq_fifo.size() != 0));
      @(posedge clk);
      #1;
      if (bq_fifo.size() != 0 && out_ready) begin
         dlog_fifo.push_back(bq_fifo.pop_front());
         dlog_data.push_back(bq_data.pop_front());
      end
      if (m_infl) begin
         bq_fifo.push_back(m_infl_fifo);
         bq_data.push_back(m_infl_data);
      end
      for (int k = 0; k < FIFOS; k++) lag[k] = (k == ep);
      m_infl = (ep >= 0);
      if (ep >= 0) begin
         m_infl_fifo = ep;
         m_infl_data = int'(fq[ep].pop_front());
         ll_q        = WIDTH'(m_infl_data);
         plog.push_back(ep);
      end else begin
         ll_q = WIDTH'($urandom);
      end
      m_ptr = n_ptr; m_cur = n_cur; m_used = n_used;
      refresh_counts();
   endtask

   // Asynchronous reset landing mid-cycle; outputs must clear before any edge
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs();
      model_clear();
      repeat (2) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < FIFOS; k++) lag[k] = 1'b0;
         refresh_counts();
      end
      rst = 1'b0;
   endtask

   task automatic run_until_idle(input int limit);
      int n = 0;
      while ((total() != 0 || bq_fifo.size() != 0 || m_infl) && n < limit) begin
         step();
         n++;
      end
      chk("drain_done", 32'(total() == 0 && bq_fifo.size() == 0 && !m_infl), 1);
      chk("drain_busy", 32'(busy), 0);
   endtask

   task automatic clear_logs();
      plog.delete();
      dlog_fifo.delete();
      dlog_data.delete();
   endtask

   function automatic int count_in_plog(input int q);
      int c = 0;
      foreach (plog[i]) if (plog[i] == q) c++;
      return c;
   endfunction

   initial begin
      int n;
      rst = 1'b1; drain_en = '0; out_ready = 1'b0; ll_q = '0; ll_count = '0;
      for (int k = 0; k < FIFOS; k++) lag[k] = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Single word from queue 3
      drain_en = '1; out_ready = 1'b1; clear_logs();
      fq[3].push_back(8'hA5);
      repeat (8) step();
      chk("t1_pops", 32'(plog.size()), 1);
      chk("t1_pop_fifo", 32'(plog.size() > 0 ? plog[0] : -1), 3);
      chk("t1_out_fifo", 32'(dlog_fifo.size() > 0 ? dlog_fifo[0] : -1), 3);
      chk("t1_out_data", 32'(dlog_data.size() > 0 ? dlog_data[0] : -1), 32'h A5);

      // Quantum: two queues of six words
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         fq[0].push_back(WIDTH'(8'h10 + i));
         fq[1].push_back(WIDTH'(8'h20 + i));
      end
      run_until_idle(100);
      exp2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
      chk("t2_pops", 32'(plog.size()), 12);
      for (int i = 0; i < 12; i++)
         if (i < plog.size()) chk($sformatf("t2_pop%0d", i), 32'(plog[i]), 32'(exp2[i]));

      // Backpressure: exactly two pops while the sink stalls
      clear_logs(); out_ready = 1'b0;
      for (int i = 0; i < 8; i++) fq[5].push_back(WIDTH'(8'h50 + i));
      repeat (10) step();
      chk("t3_stalled_pops", 32'(plog.size()), 2);
      chk("t3_stalled_q", 32'(count_in_plog(5)), 2);
      out_ready = 1'b1;
      run_until_idle(100);
      chk("t3_delivered", 32'(dlog_data.size()), 8);
      chk("t3_last_data", 32'(dlog_data.size() == 8 ? dlog_data[7] : -1), 32'h57);

      // Enable mask keeps queue 2 untouched until re-enabled
      clear_logs(); drain_en = 8'b1111_1011;
      for (int k = 0; k < FIFOS; k++) begin
         fq[k].push_back(WIDTH'(8'h80 + k));
         fq[k].push_back(WIDTH'(8'h90 + k));
      end
      repeat (20) step();
      chk("t4_masked", 32'(count_in_plog(2)), 0);
      drain_en = '1;
      run_until_idle(100);
      chk("t4_served", 32'(count_in_plog(2)), 2);

      // Count lag: two words, never a third pop
      clear_logs();
      fq[7].push_back(8'h71);
      fq[7].push_back(8'h72);
      repeat (10) step();
      chk("t5_pops", 32'(plog.size()), 2);
      chk("t5_pop_q", 32'(count_in_plog(7)), 2);

      // Reset with two words buffered, then service restarts from queue 0
      clear_logs(); out_ready = 1'b0;
      for (int k = 0; k < FIFOS; k++)
         for (int i = 0; i < 3; i++) fq[k].push_back(WIDTH'($urandom));
      n = 0;
      while (bq_fifo.size() < 2 && n < 10) begin
         step();
         n++;
      end
      chk("t6_buffered", 32'(bq_fifo.size()), 2);
      do_reset();
      clear_logs(); out_ready = 1'b1;
      step();
      chk("t6_restart_q", 32'(plog.size() > 0 ? plog[0] : -1), 0);

      // Random traffic with occasional resets
      rand_mode = 1'b1;
      for (int c = 0; c < 20000; c++) begin
         step();
         if (c % 5000 == 4999) do_reset();
      end
      rand_mode = 1'b0; drain_en = '1; out_ready = 1'b1;
      run_until_idle(2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
